// File: rtl/inv_srl_cell.sv
// inv_srl_cell -- addressable shift-register primitive with invertible D/CE pins.
//
// Golden model for inverter absorption on sequential cells. An upstream
// inverter on D or CE folds into INV_D / INV_CE, and the cell behaves
// bit-exactly as if the inverter were still present.
//
// Parameters
//   AW     tap-address width, DEPTH = 2**AW (legal 1..6)
//   INIT   register contents after reset, bit i -> stage i
//   INV_D  invert D before stage 0
//   INV_CE invert CE (active-low enable)
//   OREG   register the tap output
//
// Ports
//   CLK    rising-edge clock
//   RST    synchronous reset, active-high
//   D      serial data in
//   CE     shift enable
//   A      tap select
//   Q      selected tap, combinational or registered per OREG
//   QLAST  last stage
//   FILL   shifts since reset, saturating at DEPTH
//   FULL   FILL == DEPTH
module inv_srl_cell #(
    parameter int                  AW     = 4,
    parameter logic [(1<<AW)-1:0]  INIT   = '0,
    parameter logic                INV_D  = 1'b0,
    parameter logic                INV_CE = 1'b0,
    parameter logic                OREG   = 1'b0
) (
    input  logic                              CLK,
    input  logic                              RST,
    (* invertible_pin="INV_D" *)  input logic D,
    (* invertible_pin="INV_CE" *) input logic CE,
    input  logic [AW-1:0]                     A,
    output logic                              Q,
    output logic                              QLAST,
    output logic [AW:0]                       FILL,
    output logic                              FULL
);
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FILL_MAX = {1'b1, {AW{1'b0}}};

    // The only places the raw pins are observed.
    logic d;
    logic ce;
    assign d  = D ^ INV_D;
    assign ce = CE ^ INV_CE;

    logic [DEPTH-1:0] sr;
    logic             qreg;
    logic [DEPTH-1:0] sr_shift;
    logic [AW:0]      fill_inc;

    assign sr_shift = {sr[DEPTH-2:0], d};
    assign fill_inc = (FILL == FILL_MAX) ? FILL_MAX : FILL + 1'b1;

    // Ternary select (rather than if (ce)) so an X on ce merges into the
    // state instead of silently being treated as a hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sr   <= INIT;
            FILL <= '0;
        end else begin
            sr   <= ce ? sr_shift : sr;
            FILL <= ce ? fill_inc : FILL;
        end
    end

    // Output register tracks the tap every non-reset edge, independent of ce.
    always_ff @(posedge CLK) begin
        if (RST) qreg <= 1'b0;
        else     qreg <= sr[A];
    end

    assign Q     = OREG ? qreg : sr[A];
    assign QLAST = sr[DEPTH-1];
    assign FULL  = (FILL == FILL_MAX);
endmodule

// File: tb/tb_inv_srl_cell.sv
// Self-checking bench for inv_srl_cell: directed tables plus an
// equivalence run between an absorbed-inverter instance and an explicit one.
module tb_inv_srl_cell;
    localparam logic [15:0] INIT_TB = 16'hA5C3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       d = 1'b0, ce = 1'b0;
    logic [3:0] a = '0;
    logic       d2 = 1'b0, ce2 = 1'b0;
    logic [3:0] a2 = '0;
    logic       nd2, nce2;

    logic q0, ql0, full0, q1, ql1, full1, q2, ql2, full2, q3, ql3, full3;
    logic [4:0] fill0, fill1, fill2, fill3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Explicit inverters feeding the non-absorbed instance.
    assign nd2  = ~d2;
    assign nce2 = ~ce2;

    inv_srl_cell #(.AW(4), .INIT(INIT_TB), .INV_D(1'b0), .INV_CE(1'b0), .OREG(1'b0)) u0 (
        .CLK(clk), .RST(rst), .D(d), .CE(ce), .A(a),
        .Q(q0), .QLAST(ql0), .FILL(fill0), .FULL(full0));

    inv_srl_cell #(.AW(4), .INIT(INIT_TB), .INV_D(1'b0), .INV_CE(1'b0), .OREG(1'b1)) u1 (
        .CLK(clk), .RST(rst), .D(d), .CE(ce), .A(a),
        .Q(q1), .QLAST(ql1), .FILL(fill1), .FULL(full1));

    inv_srl_cell #(.AW(4), .INIT(16'h0000), .INV_D(1'b1), .INV_CE(1'b1), .OREG(1'b0)) u2 (
        .CLK(clk), .RST(rst), .D(d2), .CE(ce2), .A(a2),
        .Q(q2), .QLAST(ql2), .FILL(fill2), .FULL(full2));

    inv_srl_cell #(.AW(4), .INIT(16'h0000), .INV_D(1'b0), .INV_CE(1'b0), .OREG(1'b0)) u3 (
        .CLK(clk), .RST(rst), .D(nd2), .CE(nce2), .A(a2),
        .Q(q3), .QLAST(ql3), .FILL(fill3), .FULL(full3));

    typedef struct {
        logic [3:0] a;
        logic       q;
    } tap_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tap_vec_t   t1[16];
        tap_vec_t   t2[8];
        logic [3:0] drv;
        logic [15:0] msr;
        logic [4:0]  mfill;
        logic [7:0]  mexp;

        // Reset contents sweep: expected taps come straight from INIT.
        for (int i = 0; i < 16; i++) begin
            t1[i].a = 4'(i);
            t1[i].q = INIT_TB[i];
        end
        // After shifting 1,0,1,1 into INIT: sr[3:0]=1011, sr[7:4]=INIT[3:0]=0011.
        t2[0] = '{4'd0, 1'b1}; t2[1] = '{4'd1, 1'b1};
        t2[2] = '{4'd2, 1'b0}; t2[3] = '{4'd3, 1'b1};
        t2[4] = '{4'd4, 1'b1}; t2[5] = '{4'd5, 1'b1};
        t2[6] = '{4'd6, 1'b0}; t2[7] = '{4'd7, 1'b0};

        // 1: reset state
        do_reset();
        ce = 1'b0;
        foreach (t1[i]) begin
            a = t1[i].a;
            #1;
            chk($sformatf("reset_tap%0d", t1[i].a), q0, t1[i].q);
        end
        chk("reset_qlast", ql0, 1'b1);
        chk("reset_fill", fill0, 5'd0);
        chk("reset_full", full0, 1'b0);
        chk("reset_oreg_q", q1, 1'b0);

        // 2: plain shift, then hold
        drv = 4'b1101;  // applied LSB first: 1,0,1,1
        ce = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d = drv[i];
            tick();
        end
        ce = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            foreach (t2[i]) begin
                a = t2[i].a;
                #1;
                chk($sformatf("shift_p%0d_tap%0d", pass, t2[i].a), q0, t2[i].q);
            end
            chk($sformatf("shift_p%0d_fill", pass), fill0, 5'd4);
            chk($sformatf("shift_p%0d_qlast", pass), ql0, 1'b0);
            if (pass == 0) repeat (10) tick();
        end

        // 3: inverted pins; CE=0 and D=0 mean shift-in-ones
        d2 = 1'b0; ce2 = 1'b0;
        do_reset();
        repeat (15) tick();
        chk("inv_fill15", fill2, 5'd15);
        chk("inv_full15", full2, 1'b0);
        tick();
        chk("inv_fill16", fill2, 5'd16);
        chk("inv_full16", full2, 1'b1);
        for (int i = 0; i < 16; i++) begin
            a2 = 4'(i);
            #1;
            chk($sformatf("inv_tap%0d", i), q2, 1'b1);
        end
        repeat (5) tick();
        chk("inv_sat_fill", fill2, 5'd16);
        chk("inv_sat_full", full2, 1'b1);
        // CE=1 is disabled; D=1 would push zeros if the enable leaked.
        ce2 = 1'b1; d2 = 1'b1;
        repeat (3) tick();
        a2 = 4'd0;
        #1;
        chk("inv_frozen_q0", q2, 1'b1);
        chk("inv_frozen_qlast", ql2, 1'b1);
        chk("inv_frozen_fill", fill2, 5'd16);
        chk("inv_frozen_u3_q0", q3, 1'b1);
        chk("inv_frozen_u3_fill", fill3, 5'd16);

        // 5: output register lags the combinational tap by one edge
        a = 4'd0; ce = 1'b0;
        do_reset();
        chk("oreg_reset_q", q1, 1'b0);
        chk("oreg_ref_reset_q", q0, 1'b1);
        ce = 1'b1; d = 1'b0; tick();
        chk("oreg_e1_ref", q0, 1'b0);
        chk("oreg_e1_q", q1, 1'b1);
        d = 1'b1; tick();
        chk("oreg_e2_ref", q0, 1'b1);
        chk("oreg_e2_q", q1, 1'b0);
        ce = 1'b0; tick();
        chk("oreg_e3_ref", q0, 1'b1);
        chk("oreg_e3_q", q1, 1'b1);
        a = 4'd1;  // sr[1] is the shifted-in 0
        #1;
        chk("oreg_anew_ref", q0, 1'b0);
        chk("oreg_anew_q_before", q1, 1'b1);
        tick();
        chk("oreg_anew_q_after", q1, 1'b0);

        // 6: reset mid-fill wins over a coincident shift
        do_reset();
        ce = 1'b1; d = 1'b0;
        repeat (9) tick();
        chk("mid_fill9", fill0, 5'd9);
        rst = 1'b1; ce = 1'b1; d = 1'b1;
        tick();
        rst = 1'b0; ce = 1'b0;
        chk("mid_rst_fill", fill0, 5'd0);
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            #1;
            chk($sformatf("mid_rst_tap%0d", i), q0, INIT_TB[i]);
        end
        ce = 1'b1; d = 1'b0; a = 4'd0;
        tick();
        ce = 1'b0;
        chk("mid_next_fill", fill0, 5'd1);
        chk("mid_next_sr0", q0, 1'b0);
        a = 4'd1;
        #1;
        chk("mid_next_sr1", q0, INIT_TB[0]);

        // 4: equivalence against a bench model, both instances every cycle
        d2 = 1'b0; ce2 = 1'b1;
        do_reset();
        msr = '0; mfill = '0;
        for (int n = 0; n < 1000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            d2  = 1'($urandom);
            ce2 = 1'($urandom);
            a2  = 4'($urandom);
            if (rst) begin
                msr = '0; mfill = '0;
            end else if (!ce2) begin
                msr   = {msr[14:0], ~d2};
                mfill = (mfill == 5'd16) ? 5'd16 : mfill + 5'd1;
            end
            tick();
            mexp = {msr[a2], msr[15], mfill, (mfill == 5'd16)};
            chk($sformatf("eq_inv_c%0d", n), {q2, ql2, fill2, full2}, mexp);
            chk($sformatf("eq_not_c%0d", n), {q3, ql3, fill3, full3}, mexp);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/inv_srl_cell.md
Name: inv_srl_cell

Overview:
- Simulation/synthesis model of an addressable shift-register primitive whose D and CE inputs are invertible pins.
- Sits directly downstream of the `$_NOT_` cells that the integrateinv pass absorbs. The D and CE ports carry `(* invertible_pin="INV_D" *)` and `(* invertible_pin="INV_CE" *)` so that an upstream inverter folds into the matching INV_* parameter.
- The model must be bit-exact with and without inverter absorption, so it serves as the golden reference for integrateinv equivalence checks on sequential cells.

Parameters:
- AW, 4: tap-address width; DEPTH = 2**AW, legal AW range 1..6.
- INIT, {DEPTH{1'b0}}: shift-register contents after reset; bit i loads stage i.
- INV_D, 1'b0: 1 inverts D before it enters stage 0.
- INV_CE, 1'b0: 1 inverts CE, making the enable active-low.
- OREG, 1'b0: 1 adds an output register on Q.

Ports:
- CLK  in  1  rising-edge clock, sole clock
- RST  in  1  synchronous reset, active-high
- D  in  1  serial data in; invertible_pin="INV_D"
- CE  in  1  shift enable; invertible_pin="INV_CE"
- A  in  AW  tap select
- Q  out  1  selected tap (combinational or registered per OREG)
- QLAST  out  1  last stage, sr[DEPTH-1]
- FILL  out  AW+1  shifts since reset, saturating at DEPTH
- FULL  out  1  FILL == DEPTH

Behaviour:
- Effective inputs:
  - d = D ^ INV_D
  - ce = CE ^ INV_CE
  - No other logic sees the raw D or CE.
- Reset: on a CLK edge with RST=1:
  - sr <= INIT
  - FILL <= 0
  - qreg <= 0
  - RST overrides ce regardless of INV_CE.
- Outputs after reset:
  - OREG=0: Q = INIT[A].
  - OREG=1: Q = 0.
  - QLAST = INIT[DEPTH-1], FULL = 0.
- Shift: on a CLK edge with RST=0 and ce=1:
  - sr <= {sr[DEPTH-2:0], d}; sr[0] is the newest bit.
  - FILL <= (FILL==DEPTH) ? DEPTH : FILL+1.
- Hold: ce=0 leaves sr and FILL unchanged.
- Tap read:
  - Q = sr[A], combinational in A, with no glitch requirement.
  - A bit written with ce=1 at edge k is visible on Q with A=a after edge k+a, given ce=1 on each of the a intervening edges.
- OREG=1:
  - qreg <= sr[A] on every non-reset edge; this update is not gated by ce.
  - Q = qreg, so the value seen on Q lags the OREG=0 value by exactly one clock.
- QLAST = sr[DEPTH-1] always, unaffected by OREG.
- FILL:
  - Width AW+1 so that DEPTH is representable.
  - Saturates at DEPTH and never wraps.
  - FULL is combinational from FILL.
- Simultaneous events:
  - RST=1 with ce=1 resolves as reset.
  - A changing in the same cycle as a shift: Q reflects the new A against the post-edge sr.
- Reset mid-fill: the next edge with RST=1 restores INIT and FILL=0 regardless of state; shifting resumes on the following edge.
- X handling: d or ce at X propagates X into sr/FILL in simulation. No X masking.
- Equivalence requirement: an instance with INV_D=1 fed D must match, cycle for cycle, an instance with INV_D=0 fed ~D through a `$_NOT_` cell. The same holds for CE/INV_CE.

Test Plan:
1. Reset with INIT=16'hA5C3, AW=4, OREG=0:
   - RST=1 for 1 edge, then RST=0, ce=0, sweep A=0..15.
   - Required: Q follows INIT bit A (A=0 -> 1, A=2 -> 0, A=15 -> 1); QLAST=1; FILL=0; FULL=0.
2. Shift with INV_D=0, INV_CE=0:
   - Drive D=1,0,1,1 with CE=1 on 4 edges, then CE=0.
   - Required: with A=0,1,2,3, Q=1,1,0,1; FILL=4.
   - Hold 10 more edges with CE=0: no change.
3. Inverted pins with INV_D=1, INV_CE=1:
   - Drive CE=0 (effective 1) and D=0 for 16 edges.
   - Required: sr=16'hFFFF, FULL=1 after edge 16, FILL=16.
   - 5 more edges: FILL stays 16.
   - Then CE=1: sr frozen.
4. Equivalence:
   - Random D/CE for 1000 cycles into the INV_D=1/INV_CE=1 instance, and the same stimulus through two `$_NOT_` cells into the INV_D=0/INV_CE=0 instance.
   - Required: Q, QLAST, FILL, FULL identical every cycle.
5. OREG=1:
   - After reset, Q=0.
   - Shift in a single 1 with A=0.
   - Required: Q=1 exactly one edge after the OREG=0 reference instance shows 1.
   - Changing A takes effect on Q one edge later.
6. Reset mid-operation:
   - Set FILL=9, then assert RST coincident with CE=1, D=1.
   - Required after that edge: sr=INIT, FILL=0.
   - Required on the next shift edge: FILL=1, sr[0]=d.
